// File: rtl/axi_lite_pkg.sv
// Shared constants for the AXI4-Lite initiator: response codes and FSM states.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_e;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: converts single-beat core load/store requests into
// AXI-Lite read/write transactions, one outstanding at a time.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned AXI_AWIDTH = 32,
    parameter int unsigned AXI_DWIDTH = 32
) (
    input  logic                    AXI_ACLK,
    input  logic                    AXI_ARESETN,
    // core request / response
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [AXI_AWIDTH-1:0]   req_addr,
    input  logic [AXI_DWIDTH-1:0]   req_wdata,
    input  logic [AXI_DWIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    output logic [AXI_DWIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    // write address / data / response channels
    output logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
    output logic                    AXI_AWVALID,
    input  logic                    AXI_AWREADY,
    output logic [AXI_DWIDTH-1:0]   AXI_WDATA,
    output logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
    output logic                    AXI_WVALID,
    input  logic                    AXI_WREADY,
    input  logic [1:0]              AXI_BRESP,
    input  logic                    AXI_BVALID,
    output logic                    AXI_BREADY,
    // read address / data channels
    output logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
    output logic                    AXI_ARVALID,
    input  logic                    AXI_ARREADY,
    input  logic [AXI_DWIDTH-1:0]   AXI_RDATA,
    input  logic [1:0]              AXI_RRESP,
    input  logic                    AXI_RVALID,
    output logic                    AXI_RREADY
);

    localparam int unsigned STRB_W = AXI_DWIDTH / 8;

    state_e                  state_q, state_d;
    logic [AXI_AWIDTH-1:0]   addr_q, addr_d;
    logic [AXI_DWIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    b_seen_q, b_seen_d;
    logic                    ar_done_q, ar_done_d;
    logic                    r_seen_q, r_seen_d;
    logic                    err_q, err_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [AXI_DWIDTH-1:0]   rdata_q, rdata_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign aw_hs = awvalid_q & AXI_AWREADY;
    assign w_hs  = wvalid_q  & AXI_WREADY;
    assign b_hs  = bready_q  & AXI_BVALID;
    assign ar_hs = arvalid_q & AXI_ARREADY;
    assign r_hs  = rready_q  & AXI_RVALID;

    // Next-state logic: accept in IDLE, track per-channel handshakes, complete when all seen
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        b_seen_d    = b_seen_q;
        ar_done_d   = ar_done_q;
        r_seen_d    = r_seen_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    b_seen_d  = 1'b0;
                    ar_done_d = 1'b0;
                    r_seen_d  = 1'b0;
                    err_d     = 1'b0;
                    if (req_we) begin
                        wdata_d   = req_wdata;
                        wstrb_d   = req_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        state_d   = RD;
                    end
                end
            end
            WR: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // an early B (before AW/W finish) is still recorded; completion waits
                if (b_hs) begin
                    b_seen_d = 1'b1;
                    err_d    = (AXI_BRESP != RESP_OKAY);
                end
                if (aw_done_d && w_done_d && b_seen_d) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_d;
                    state_d     = IDLE;
                end
            end
            RD: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    ar_done_d = 1'b1;
                end
                if (r_hs) begin
                    r_seen_d = 1'b1;
                    rdata_d  = AXI_RDATA;
                    err_d    = (AXI_RRESP != RESP_OKAY);
                end
                if (ar_done_d && r_seen_d) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_d;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any pending transaction
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            b_seen_q    <= 1'b0;
            ar_done_q   <= 1'b0;
            r_seen_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            b_seen_q    <= b_seen_d;
            ar_done_q   <= ar_done_d;
            r_seen_q    <= r_seen_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = rsp_err_q;
    assign AXI_AWADDR  = addr_q;
    assign AXI_AWVALID = awvalid_q;
    assign AXI_WDATA   = wdata_q;
    assign AXI_WSTRB   = wstrb_q;
    assign AXI_WVALID  = wvalid_q;
    assign AXI_BREADY  = bready_q;
    assign AXI_ARADDR  = addr_q;
    assign AXI_ARVALID = arvalid_q;
    assign AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed testbench for axi_lite_master with a small memory / skewed slave BFM.
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    axi_lite_master #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) dut (
        .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
        .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
        .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
        .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
        .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // slave behaviour: 0 = zero-wait memory, 1 = skewed, other = stall everything
    int mode = 0;
    logic [31:0] ram [0:15];
    int wcnt = 0;
    int rcnt = 0;

    // Slave BFM: decides READY/VALID on the falling edge for the next rising edge
    always @(negedge clk) begin
        case (mode)
            0: begin
                bresp = 2'b00;
                rresp = 2'b00;
                if (awvalid && wvalid && bready) begin
                    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) ram[awaddr[5:2]][8*b +: 8] = wdata[8*b +: 8];
                end else begin
                    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
                end
                if (arvalid && rready) begin
                    arready = 1'b1; rvalid = 1'b1; rdata = ram[araddr[5:2]];
                end else begin
                    arready = 1'b0; rvalid = 1'b0;
                end
            end
            1: begin
                bresp = 2'b00;
                rresp = 2'b10;
                rdata = 32'h12345678;
                if (bready) begin
                    wready  = (wcnt == 0);
                    awready = (wcnt == 3);
                    bvalid  = (wcnt == 5);
                    wcnt++;
                end else begin
                    wready = 1'b0; awready = 1'b0; bvalid = 1'b0; wcnt = 0;
                end
                if (rready) begin
                    arready = (rcnt == 1);
                    rvalid  = (rcnt == 5);
                    rcnt++;
                end else begin
                    arready = 1'b0; rvalid = 1'b0; rcnt = 0;
                end
            end
            default: begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
                arready = 1'b0; rvalid = 1'b0; bresp = 2'b00; rresp = 2'b00;
            end
        endcase
    end

    // Monitor: counts VALID cycles and pulses, flags VALID/payload instability
    int   aw_cyc = 0, w_cyc = 0, ar_cyc = 0, rsp_cnt = 0, rready_bad = 0, stab_err = 0;
    logic w_drop_seen = 1'b0;
    logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0;
    logic [3:0]  p_wstrb = 0;
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            p_awv = 0; p_wv = 0; p_arv = 0;
        end else begin
            if (awvalid) aw_cyc++;
            if (wvalid) w_cyc++;
            if (arvalid) ar_cyc++;
            if (rsp_valid) rsp_cnt++;
            if (arvalid && !rready) rready_bad++;
            if (awvalid && !wvalid) w_drop_seen = 1'b1;
            if (p_awv && !p_awr && (!awvalid || awaddr != p_awaddr)) stab_err++;
            if (p_wv && !p_wr && (!wvalid || wdata != p_wdata || wstrb != p_wstrb)) stab_err++;
            if (p_arv && !p_arr && (!arvalid || araddr != p_araddr)) stab_err++;
            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
            p_arv = arvalid; p_arr = arready; p_araddr = araddr;
        end
    end

    // One request through the DUT; latency counted from the accepting cycle
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, output int lat, output logic err,
                          output logic [31:0] rd, output logic one_pulse);
        int n;
        int acc;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = strb;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: no rsp_valid within 50 cycles, required a response");
        end
        lat = cyc - acc;
        err = rsp_err;
        rd  = rsp_rdata;
        @(negedge clk);
        one_pulse = !rsp_valid && !rsp_err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err});
        end
        checks++;
        if (rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h required 0", rsp_rdata);
        end
        checks++;
        if ({awaddr, wdata, wstrb, araddr} !== 100'h0) begin
            errors++; $display("FAIL reset_payload: got %h %h %h %h required 0", awaddr, wdata, wstrb, araddr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_write_mem();
        int lat; logic err, pulse; logic [31:0] rd;
        int aw0, w0;
        mode = 0; aw0 = aw_cyc; w0 = w_cyc;
        do_req(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, lat, err, rd, pulse);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d required 2", lat); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b required 0", err); end
        checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL wr_pulse: rsp not a single clean pulse"); end
        checks++; if (aw_cyc - aw0 !== 1) begin errors++; $display("FAIL wr_awvalid_cycles: got %0d required 1", aw_cyc - aw0); end
        checks++; if (w_cyc - w0 !== 1) begin errors++; $display("FAIL wr_wvalid_cycles: got %0d required 1", w_cyc - w0); end
        checks++; if (ram[4] !== 32'hCAFEF00D) begin errors++; $display("FAIL wr_ram: got %h required cafef00d", ram[4]); end
    endtask

    task automatic test_read_mem();
        int lat; logic err, pulse; logic [31:0] rd;
        int ar0, rb0;
        mode = 0; ar0 = ar_cyc; rb0 = rready_bad;
        do_req(1'b0, 32'h10, 32'h0, 4'h0, lat, err, rd, pulse);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_data: got %h required cafef00d", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b required 0", err); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d required 2", lat); end
        checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL rd_pulse: rsp not a single clean pulse"); end
        checks++; if (rready_bad - rb0 !== 0 || ar_cyc - ar0 !== 1) begin
            errors++; $display("FAIL rd_ar_cycle: rready_low=%0d ar_cycles=%0d required 0 and 1", rready_bad - rb0, ar_cyc - ar0);
        end
    endtask

    task automatic test_partial();
        int lat; logic err, pulse; logic [31:0] rd;
        mode = 0;
        do_req(1'b1, 32'h10, 32'h0000AB00, 4'h2, lat, err, rd, pulse);
        checks++; if (ram[4] !== 32'hCAFEAB0D) begin errors++; $display("FAIL partial_ram: got %h required cafeab0d", ram[4]); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, lat, err, rd, pulse);
        checks++; if (rd !== 32'hCAFEAB0D) begin errors++; $display("FAIL partial_read: got %h required cafeab0d", rd); end
    endtask

    task automatic test_skewed();
        int lat; logic err, pulse; logic [31:0] rd;
        int aw0, w0, ar0;
        mode = 1; w_drop_seen = 1'b0; aw0 = aw_cyc; w0 = w_cyc; ar0 = ar_cyc;
        do_req(1'b1, 32'h20, 32'h55AA55AA, 4'hF, lat, err, rd, pulse);
        checks++; if (w_drop_seen !== 1'b1) begin errors++; $display("FAIL skew_wdrop: got %b required 1", w_drop_seen); end
        checks++; if (aw_cyc - aw0 !== 4 || w_cyc - w0 !== 1) begin
            errors++; $display("FAIL skew_valid_cycles: aw=%0d w=%0d required 4 and 1", aw_cyc - aw0, w_cyc - w0);
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL skew_wr_err: got %b required 0", err); end
        checks++; if (lat !== 7) begin errors++; $display("FAIL skew_wr_latency: got %0d required 7", lat); end
        do_req(1'b0, 32'h24, 32'h0, 4'h0, lat, err, rd, pulse);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL skew_rd_data: got %h required 12345678", rd); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL skew_rd_err: got %b required 1", err); end
        checks++; if (lat !== 7) begin errors++; $display("FAIL skew_rd_latency: got %0d required 7", lat); end
        checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL skew_rd_pulse: rsp/err not cleared after one cycle"); end
        checks++; if (ar_cyc - ar0 !== 2) begin errors++; $display("FAIL skew_ar_cycles: got %0d required 2", ar_cyc - ar0); end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL valid_stability: got %0d violations required 0", stab_err); end
    endtask

    task automatic test_back_to_back();
        logic        we_t [4];
        logic [31:0] ad_t [4];
        logic [31:0] wd_t [4];
        int idx, seen, n, r0, acc_n;
        logic took;
        we_t[0] = 1'b1; ad_t[0] = 32'h14; wd_t[0] = 32'h11112222;
        we_t[1] = 1'b0; ad_t[1] = 32'h14; wd_t[1] = 32'h11112222;
        we_t[2] = 1'b1; ad_t[2] = 32'h18; wd_t[2] = 32'h33334444;
        we_t[3] = 1'b0; ad_t[3] = 32'h18; wd_t[3] = 32'h33334444;
        mode = 0; idx = 0; seen = 0; n = 0; acc_n = 0; r0 = rsp_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = we_t[0]; req_addr = ad_t[0]; req_wdata = wd_t[0]; req_wstrb = 4'hF;
        while (seen < 4 && n < 60) begin
            took = 1'b0;
            if (rsp_valid) begin
                if (!we_t[seen]) begin
                    checks++;
                    if (rsp_rdata !== wd_t[seen]) begin
                        errors++; $display("FAIL b2b_rdata%0d: got %h required %h", seen, rsp_rdata, wd_t[seen]);
                    end
                end
                seen++;
            end
            if (req_valid && req_ready) begin
                if (idx > 0) begin
                    checks++;
                    if (rsp_valid !== 1'b1) begin
                        errors++; $display("FAIL b2b_accept%0d: rsp_valid=%b at accept required 1", idx, rsp_valid);
                    end
                end
                took = 1'b1;
                acc_n++;
            end
            @(negedge clk);
            if (took) begin
                idx++;
                if (idx < 4) begin
                    req_we = we_t[idx]; req_addr = ad_t[idx]; req_wdata = wd_t[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            n++;
        end
        repeat (2) @(negedge clk);
        checks++; if (acc_n !== 4) begin errors++; $display("FAIL b2b_accepts: got %0d required 4", acc_n); end
        checks++; if (rsp_cnt - r0 !== 4) begin errors++; $display("FAIL b2b_pulses: got %0d required 4", rsp_cnt - r0); end
    endtask

    task automatic test_reset_mid();
        int lat, r0; logic err, pulse; logic [31:0] rd;
        mode = 2; r0 = rsp_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hDEADBEEF; req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (awvalid !== 1'b1) begin errors++; $display("FAIL mid_awvalid: got %b required 1", awvalid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0) begin
            errors++; $display("FAIL mid_async_clear: got %b required 000000",
                               {awvalid, wvalid, bready, arvalid, rready, rsp_valid});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rsp_cnt !== r0) begin errors++; $display("FAIL mid_no_rsp: got %0d pulses required 0", rsp_cnt - r0); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_req_ready: got %b required 1", req_ready); end
        mode = 0;
        do_req(1'b0, 32'h10, 32'h0, 4'h0, lat, err, rd, pulse);
        checks++; if (rd !== 32'hCAFEAB0D || err !== 1'b0 || lat !== 2) begin
            errors++; $display("FAIL mid_read_after: data=%h err=%b lat=%0d required cafeab0d 0 2", rd, err, lat);
        end
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
        for (int i = 0; i < 16; i++) ram[i] = 32'h0;
        test_reset();
        test_write_mem();
        test_read_mem();
        test_partial();
        test_skewed();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
